// File: rtl/spi_pkg.sv
// Shared SPI constants and types, used by the receiver and the transmitter.
package spi_pkg;

    // Default word width for both ends of the link.
    localparam int SPI_DATA_W = 8;

    // Chip select is active low.
    localparam logic SPI_CS_ACTIVE = 1'b0;

    // Receiver frame state.
    typedef enum logic [1:0] {
        SPI_RX_IDLE  = 2'd0,
        SPI_RX_SHIFT = 2'd1,
        SPI_RX_ERR   = 2'd2
    } spi_rx_state_e;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchroniser for one asynchronous input, with a selectable reset value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain; the last stage is the clean copy.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// Oversampling SPI (mode 0, MSB first) slave receiver with a one-entry
// valid/ready output register, overrun and truncated-frame flags.
// Optional feature: define SPI_RX_ERR_CNT_EN to add the saturating err_cnt port.
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              spi_cs,
    input  logic              spi_clk,
    input  logic              spi_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_busy,
    output logic              rx_overrun,
    output logic              rx_frame_err
`ifdef SPI_RX_ERR_CNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [1:0]        FLUSHED  = 2'(SYNC_STAGES);

    // Synchronised SPI lines.
    logic s_cs;
    logic s_clk;
    logic s_data;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (RST),
        .d   (spi_cs),
        .q   (s_cs)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk (clk),
        .rst (RST),
        .d   (spi_clk),
        .q   (s_clk)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
        .clk (clk),
        .rst (RST),
        .d   (spi_data),
        .q   (s_data)
    );

    // Edge detection and frame arming.
    logic       s_clk_d;
    logic       s_cs_d;
    logic [1:0] flush_cnt;
    logic       armed;
    logic       rise;
    logic       cs_fall;
    logic       cs_rise;

    // Delayed copies for edge detection. The synchroniser reset values are not
    // real samples, so a CS fall is honoured only after CS has been seen
    // inactive once the chains have flushed; a frame already running at reset
    // release is therefore skipped.
    always_ff @(posedge clk) begin
        if (RST) begin
            s_clk_d   <= 1'b0;
            s_cs_d    <= 1'b1;
            flush_cnt <= 2'd0;
            armed     <= 1'b0;
        end else begin
            s_clk_d <= s_clk;
            s_cs_d  <= s_cs;
            if (flush_cnt != FLUSHED) begin
                flush_cnt <= flush_cnt + 2'd1;
            end
            if (flush_cnt == FLUSHED && s_cs != SPI_CS_ACTIVE) begin
                armed <= 1'b1;
            end
        end
    end

    assign rise    = s_clk & ~s_clk_d;
    assign cs_fall = armed & (s_cs == SPI_CS_ACTIVE) & (s_cs_d != SPI_CS_ACTIVE);
    assign cs_rise = (s_cs != SPI_CS_ACTIVE) & (s_cs_d == SPI_CS_ACTIVE);

    // Frame state machine.
    spi_rx_state_e     state,   state_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg,   shreg_n;
    logic [DATA_W-1:0] word_q,  word_n;
    logic              word_done, done_n;
    logic [DATA_W-1:0] shifted;

    assign shifted = {shreg[DATA_W-2:0], s_data};

    // State register plus the completed-word stage feeding the output register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= SPI_RX_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            word_q    <= '0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            word_q    <= word_n;
            word_done <= done_n;
        end
    end

    // Next state: a clock rise is processed before a CS rise in the same cycle,
    // so the CS decision uses the post-shift bit count.
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        word_n    = word_q;
        done_n    = 1'b0;
        case (state)
            SPI_RX_IDLE: begin
                bit_cnt_n = '0;
                shreg_n   = '0;
                if (cs_fall) begin
                    state_n = SPI_RX_SHIFT;
                end
            end
            SPI_RX_SHIFT: begin
                if (rise) begin
                    if (bit_cnt == LAST_BIT) begin
                        done_n    = 1'b1;
                        word_n    = shifted;
                        bit_cnt_n = '0;
                        shreg_n   = '0;
                    end else begin
                        shreg_n   = shifted;
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
                if (cs_rise) begin
                    state_n = (bit_cnt_n == '0) ? SPI_RX_IDLE : SPI_RX_ERR;
                end
            end
            SPI_RX_ERR: begin
                bit_cnt_n = '0;
                shreg_n   = '0;
                state_n   = SPI_RX_IDLE;
            end
            default: begin
                state_n = SPI_RX_IDLE;
            end
        endcase
    end

    // One-entry output register: a new word loads when empty or when the held
    // word is handed off in the same cycle; otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (RST) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= word_q;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_frame_err = (state == SPI_RX_ERR);
    assign rx_busy      = (s_cs == SPI_CS_ACTIVE);

`ifdef SPI_RX_ERR_CNT_EN
    // Saturating count of error cycles; simultaneous pulses count once.
    always_ff @(posedge clk) begin
        if (RST) begin
            err_cnt <= 16'd0;
        end else if ((rx_overrun || rx_frame_err) && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: table of single-frame vectors plus
// hand-written sequences for multi-word, overrun, reset and rate corners.
module tb_spi_rx;

    logic       clk;
    logic       RST;
    logic       spi_cs;
    logic       spi_clk;
    logic       spi_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;
`ifdef SPI_RX_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    spi_rx dut (
        .clk          (clk),
        .RST          (RST),
        .spi_cs       (spi_cs),
        .spi_clk      (spi_clk),
        .spi_data     (spi_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_busy      (rx_busy),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
`ifdef SPI_RX_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed traffic, sampled mid-way between the driving negedge and the next posedge.
    logic [7:0] q_rx[$];
    int         n_ovr  = 0;
    int         n_ferr = 0;

    always @(negedge clk) begin
        #5;
        if (!RST) begin
            if (rx_valid && rx_ready) q_rx.push_back(rx_data);
            if (rx_overrun)           n_ovr++;
            if (rx_frame_err)         n_ferr++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input int half);
        spi_data = b;
        repeat (half) @(negedge clk);
        spi_clk = 1'b1;
        repeat (half) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int nbits, input int half);
        for (int i = nbits - 1; i >= 0; i--) spi_bit(v[i], half);
    endtask

    task automatic do_frame(input logic [31:0] v, input int nbits, input int half);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(v, nbits, half);
        repeat (half) @(negedge clk);
        spi_cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic frame_words(input logic [7:0] w [4], input int n, input int half);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) send_bits({24'd0, w[i]}, 8, half);
        repeat (half) @(negedge clk);
        spi_cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        string      name;
        logic [31:0] v;
        int         nbits;
        int         half;
        int         exp_xfers;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nx, nf, no;
        logic [7:0] w [4];

        vec[0] = '{"a5_clk8",      32'h0A5,  8, 4, 1, 8'hA5, 0};
        vec[1] = '{"zero_clk4",    32'h000,  8, 2, 1, 8'h00, 0};
        vec[2] = '{"ones_clk4",    32'h0FF,  8, 2, 1, 8'hFF, 0};
        vec[3] = '{"trunc5",       32'h016,  5, 4, 0, 8'h00, 1};
        vec[4] = '{"after_trunc",  32'h081,  8, 4, 1, 8'h81, 0};
        vec[5] = '{"trunc1",       32'h001,  1, 4, 0, 8'h00, 1};
        vec[6] = '{"empty_frame",  32'h000,  0, 4, 0, 8'h00, 0};
        vec[7] = '{"word_plus1",   32'h0B5,  9, 4, 1, 8'h5A, 1};

        RST      = 1'b1;
        spi_cs   = 1'b1;
        spi_clk  = 1'b0;
        spi_data = 1'b0;
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);

        check("rst/rx_data",      rx_data,      0);
        check("rst/rx_valid",     rx_valid,     0);
        check("rst/rx_busy",      rx_busy,      0);
        check("rst/rx_overrun",   rx_overrun,   0);
        check("rst/rx_frame_err", rx_frame_err, 0);
`ifdef SPI_RX_ERR_CNT_EN
        check("rst/err_cnt",      err_cnt,      0);
`endif
        RST = 1'b0;
        repeat (5) @(negedge clk);

        // Single-frame vectors.
        for (int i = 0; i < NV; i++) begin
            nx = q_rx.size();
            nf = n_ferr;
            no = n_ovr;
            do_frame(vec[i].v, vec[i].nbits, vec[i].half);
            check({vec[i].name, "/xfers"}, q_rx.size() - nx, vec[i].exp_xfers);
            if (vec[i].exp_xfers > 0) check({vec[i].name, "/data"}, q_rx[$], vec[i].exp_data);
            check({vec[i].name, "/frame_err"}, n_ferr - nf, vec[i].exp_ferr);
            check({vec[i].name, "/overrun"},   n_ovr - no,  0);
            check({vec[i].name, "/busy"},      rx_busy,     0);
            check({vec[i].name, "/valid"},     rx_valid,    0);
        end

        // Multi-word frame under one CS.
        nx = q_rx.size();
        nf = n_ferr;
        w  = '{8'h3C, 8'hFF, 8'h00, 8'h00};
        frame_words(w, 3, 4);
        check("multi/xfers", q_rx.size() - nx, 3);
        check("multi/w0", q_rx[nx],     8'h3C);
        check("multi/w1", q_rx[nx + 1], 8'hFF);
        check("multi/w2", q_rx[nx + 2], 8'h00);
        check("multi/frame_err", n_ferr - nf, 0);

        // Overrun with the consumer stalled.
        pulse_reset();
        rx_ready = 1'b0;
        nx = q_rx.size();
        no = n_ovr;
        w  = '{8'h11, 8'h22, 8'h00, 8'h00};
        frame_words(w, 2, 4);
        check("ovr/valid",   rx_valid, 1);
        check("ovr/data",    rx_data,  8'h11);
        check("ovr/pulses",  n_ovr - no, 1);
`ifdef SPI_RX_ERR_CNT_EN
        check("ovr/err_cnt", err_cnt, 1);
`endif
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr/drain_xfers", q_rx.size() - nx, 1);
        check("ovr/drain_data",  q_rx[$], 8'h11);
        check("ovr/valid_fall",  rx_valid, 0);

        // Handshake in the very cycle a new word lands: load, not overrun.
        rx_ready = 1'b0;
        nx = q_rx.size();
        no = n_ovr;
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(32'h33, 8, 4);
        send_bits(32'h44 >> 1, 7, 4);
        spi_data = 1'b0;
        repeat (4) @(negedge clk);
        spi_clk = 1'b1;
        repeat (3) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        spi_clk  = 1'b0;
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (10) @(negedge clk);
        check("b2b/xfers",   q_rx.size() - nx, 1);
        check("b2b/first",   q_rx[$], 8'h33);
        check("b2b/held",    rx_data, 8'h44);
        check("b2b/valid",   rx_valid, 1);
        check("b2b/overrun", n_ovr - no, 0);
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("b2b/second",  q_rx[$], 8'h44);

        // Reset in the middle of a frame, CS held low across it.
        nx = q_rx.size();
        nf = n_ferr;
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(32'hA, 4, 4);
        RST = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst/rx_data",  rx_data,      0);
        check("midrst/rx_valid", rx_valid,     0);
        check("midrst/rx_busy",  rx_busy,      0);
        check("midrst/ferr",     rx_frame_err, 0);
        RST = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(32'hC3, 8, 4);
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst/ignored_xfers", q_rx.size() - nx, 0);
        check("midrst/no_ferr",       n_ferr - nf,      0);
        do_frame(32'h5E, 8, 4);
        check("midrst/next_xfers", q_rx.size() - nx, 1);
        check("midrst/next_data",  q_rx[$], 8'h5E);

        // Maximum SPI rate with the consumer toggling every cycle.
        begin
            bit done;
            done = 1'b0;
            nx = q_rx.size();
            no = n_ovr;
            w  = '{8'h12, 8'h34, 8'h56, 8'h78};
            fork
                begin
                    frame_words(w, 4, 2);
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(negedge clk);
                        rx_ready = ~rx_ready;
                    end
                end
            join
            rx_ready = 1'b1;
            repeat (4) @(negedge clk);
        end
        check("max/xfers",   q_rx.size() - nx, 4);
        check("max/w0",      q_rx[nx],     8'h12);
        check("max/w1",      q_rx[nx + 1], 8'h34);
        check("max/w2",      q_rx[nx + 2], 8'h56);
        check("max/w3",      q_rx[nx + 3], 8'h78);
        check("max/overrun", n_ovr - no,   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_rx.md
# spi_rx

Oversampling SPI slave receiver: the receiving end of the `top` SPI transmit link (`spi_cs`, `spi_clk`, `spi_data`). It synchronises the three SPI lines into the 50 MHz system clock domain, deserialises MSB-first mode-0 words, and presents each word on a one-entry valid/ready output register. It also flags overruns and truncated frames. It is used in loopback benches and as the receive front-end of any board that consumes the `top` stream.

## Interface
- `DATA_W`, 8: bits per word; 2..32.
- `SYNC_STAGES`, 2: synchroniser flops per SPI input; 2..3.
- `clk`  in  1  system clock, 50 MHz; all logic on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `spi_cs`  in  1  chip select, active low; asynchronous to `clk`.
- `spi_clk`  in  1  SPI clock, idle low; data is sampled on its rising edge. Frequency must be ≤ clk/4.
- `spi_data`  in  1  serial data, MSB first.
- `rx_data`  out  DATA_W  received word; stable while `rx_valid` is high.
- `rx_valid`  out  1  word available.
- `rx_ready`  in  1  consumer accepts; transfer occurs when `rx_valid & rx_ready`.
- `rx_busy`  out  1  a frame is in progress (synchronised CS low).
- `rx_overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `rx_frame_err`  out  1  one-cycle pulse: CS deasserted with a partial word.
- `err_cnt`  out  16  saturating error count; present only with `SPI_RX_ERR_CNT_EN`.

## Operation
- **Synchronisers.** Each SPI input passes through `SYNC_STAGES` flops. Reset values are: CS chain 1, clk chain 0, data chain 0.
- **Edge detection.** One extra flop on synchronised `spi_clk` produces `rise = s_clk & ~s_clk_d`. Synchronised `spi_cs` is handled the same way to produce `cs_fall` and `cs_rise`.
- **State machine.** States are IDLE, SHIFT, ERR.
  - IDLE: `bit_cnt`=0 and `shreg`=0. On `cs_fall`, go to SHIFT.
  - SHIFT: on each `rise`, set `shreg <= {shreg[DATA_W-2:0], s_data}` and `bit_cnt++`.
    - When `bit_cnt` reaches `DATA_W-1` on a `rise`, the word is complete. Load `{shreg[DATA_W-2:0], s_data}` into the output register, set `bit_cnt` to 0, and stay in SHIFT. Multi-word frames under a single CS are supported.
    - On `cs_rise` with `bit_cnt==0`, go to IDLE.
    - On `cs_rise` with `bit_cnt!=0`, go to ERR.
  - ERR: pulse `rx_frame_err` for one cycle, discard `shreg`, then go to IDLE in the next cycle.
- **Simultaneous events.** If `rise` and `cs_rise` occur in the same cycle, the `rise` is processed first. If it completes the word, the word is delivered and there is no frame error.
- **Output register.**
  - A completed word is loaded when `!rx_valid`, or when `rx_valid & rx_ready` in the same cycle (back-to-back).
  - Otherwise the new word is dropped, the held word is kept unchanged, and `rx_overrun` pulses.
  - `rx_valid` falls on a handshake with no new word arriving.
- **Busy flag.** `rx_busy` equals `~s_cs` (synchronised, not edge-delayed).
- **Reset.** `RST` mid-frame aborts with no error pulse. The block returns to IDLE and waits for the next `cs_fall`; a frame whose CS was already low at reset release is ignored until CS rises and falls again.

## Timing
- **Reset values.** `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `rx_overrun`=0, `rx_frame_err`=0, `err_cnt`=0.
- **Latency.** Let T be the `clk` edge that first captures the raw `spi_clk` high for the last bit. `rx_valid` is high after edge T+SYNC_STAGES+1, which is T+3 with the defaults.
- **SPI clock spacing.** Minimum `spi_clk` high and low time is 2 `clk` periods. Shorter pulses may be lost; this is not detected.
- **Data setup.** `spi_data` must be stable from at least 1 `clk` period before until 1 `clk` period after the `spi_clk` rising edge. Data and clock use equal-length synchronisers, so their alignment is preserved.
- **Throughput.** One word per DATA_W SPI clocks. With `rx_ready` tied high, no word is ever lost.

## Configuration
- `SPI_RX_ERR_CNT_EN` defined:
  - adds the `err_cnt` port and a 16-bit counter;
  - the counter increments on each `rx_overrun` or `rx_frame_err` pulse (both in the same cycle counts +1);
  - it saturates at 0xFFFF and is cleared only by `RST`.
- `SPI_RX_ERR_CNT_EN` undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- **Shared package `spi_pkg`.** Holds the state enum (`SPI_RX_IDLE`, `SPI_RX_SHIFT`, `SPI_RX_ERR`), default `DATA_W`, and the CS polarity constant (`SPI_CS_ACTIVE = 1'b0`). The same constants are shared with the transmitter.
- **Sub-module `spi_sync`.** Parameterised N-stage synchroniser with a configurable reset value, instantiated three times. Edge detection stays in `spi_rx`.

## Test plan
- **Single word.** Reset, then CS low, send 0xA5 at spi_clk = clk/8 with `rx_ready`=1, then CS high. Required: one `rx_valid` cycle with `rx_data`=0xA5; no error pulses; `rx_busy` returns to 0.
- **Multi-word frame.** Send 0x3C, 0xFF, 0x00 under one CS. Required: three valid transfers in order, no frame error.
- **Truncated frame.** Send 5 bits (10110) and then raise CS. Required: exactly one `rx_frame_err` pulse, no `rx_valid`, and the next full word 0x81 is received correctly.
- **Overrun.** Hold `rx_ready`=0 and send 0x11 then 0x22. Required: `rx_data` stays 0x11, one `rx_overrun` pulse, and `err_cnt`=1 when the macro is defined. Then assert `rx_ready`. Required: 0x11 is accepted and `rx_valid` falls.
- **Reset mid-frame.** Pulse `RST` after 4 bits with CS still low. Required: all outputs return to reset values, no error pulse, and nothing is received until CS rises and falls again.
- **Back-to-back at maximum rate.** Run spi_clk = clk/4 with `rx_ready` toggling every cycle. Required: no word lost, because the load happens on the same cycle as the handshake.
